// File: rtl/datapath_sequencer_if.sv
// rtl/datapath_sequencer_if.sv - instruction handshake and datapath control bundle
// The master side drives instructions and stalls, and the slave side drives the datapath controls.
interface datapath_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic             instr_valid;
  logic [15:0]      instr_in;
  logic             instr_ready;
  logic             hold;
  logic [15:0]      wEnable;
  logic [7:0]       opcode;
  logic [3:0]       Rdest_select;
  logic [3:0]       Rsrc_select;
  logic [15:0]      Imm_in;
  logic             Imm_select;
  logic             busy;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output instr_valid, instr_in, hold,
    input  instr_ready, wEnable, opcode, Rdest_select, Rsrc_select,
           Imm_in, Imm_select, busy, retire, retired_cnt
  );

  modport slave (
    input  instr_valid, instr_in, hold,
    output instr_ready, wEnable, opcode, Rdest_select, Rsrc_select,
           Imm_in, Imm_select, busy, retire, retired_cnt
  );
endinterface

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - four-step issue controller for the register-file/ALU datapath
// Decode outputs are combinational from IR, so they stay stable until the next accept.
module datapath_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [15:0]      ir;
  logic             accept;
  logic             ready;
  logic [15:0]      wen;
  logic             retire_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_hi;
  logic [3:0]       op_ext;
  logic             no_write;
  logic             zero_ext;

  assign op_hi    = ir[15:12];
  assign op_ext   = ir[7:4];
  assign no_write = ((op_hi == 4'h0) && (op_ext == 4'hB)) || (op_hi == 4'hB);
  assign zero_ext = (op_hi == 4'h1) || (op_hi == 4'h2) || (op_hi == 4'h3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept     = 1'b0;
    wen        = 16'h0000;
    case (state)
      IDLE: begin
        ready = !bus.hold;
        if (bus.instr_valid && !bus.hold) begin
          accept     = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (!bus.hold) state_next = EXECUTE;
      end
      EXECUTE: begin
        if (!bus.hold) state_next = WRITEBACK;
      end
      WRITEBACK: begin
        // The write lands on the single unheld WRITEBACK cycle; a reset in that cycle cancels it.
        if (!bus.hold) begin
          state_next = IDLE;
          if (!no_write && !reset) wen = 16'h0001 << ir[11:8];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir <= 16'h0000;
    end else if (accept) begin
      ir <= bus.instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= 1'b0;
      cnt_q    <= '0;
    end else if (!bus.hold) begin
      retire_q <= (state == WRITEBACK);
      if (state == WRITEBACK) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.instr_ready  = ready;
  assign bus.wEnable      = wen;
  assign bus.busy         = (state != IDLE);
  assign bus.retire       = retire_q;
  assign bus.retired_cnt  = cnt_q;
  assign bus.Rdest_select = ir[11:8];
  assign bus.Rsrc_select  = ir[3:0];
  assign bus.opcode       = (op_hi == 4'h0) ? {4'h0, op_ext} : {op_hi, 4'h0};
  assign bus.Imm_select   = (op_hi != 4'h0);
  assign bus.Imm_in       = zero_ext ? {8'h00, ir[7:0]} : {{8{ir[7]}}, ir[7:0]};

endmodule
